// File: rtl/uart_mmio_ctrl.sv
// rtl/uart_mmio_ctrl.sv - memory-mapped UART controller with TX/RX FIFOs
// Decouples RV32I load/store access from the UART core's serial handshake.
module uart_mmio_ctrl #(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_addr,
  input  logic        i_wr,
  input  logic        i_rd,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_rvalid,
  output logic        o_en,
  output logic [3:0]  o_br,
  output logic [7:0]  o_clk_dec,
  output logic        o_str_tx,
  output logic [7:0]  o_data_tx,
  input  logic        i_busy_tx,
  input  logic        i_rxne,
  input  logic [7:0]  i_data_rx,
  output logic        o_irq
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);

  typedef enum logic [1:0] {T_IDLE, T_REQ, T_ACTIVE, T_GAP} tx_state_t;

  tx_state_t    tx_state;
  logic [31:0]  ctrl;
  logic [7:0]   tx_mem [TX_DEPTH];
  logic [7:0]   rx_mem [RX_DEPTH];
  logic [TAW:0] tx_wp, tx_rp;
  logic [RAW:0] rx_wp, rx_rp, rx_cnt;
  logic         rx_ovr, rxne_d, gap_cnt;
  logic         tx_full, tx_empty, rx_full, rx_empty, tx_active;
  logic         rd, wr_ctrl, wr_stat, wr_tx, rd_rx, flush;
  logic         tx_pop, tx_push, rx_rise, rx_pop, rx_push, rx_drop;
  logic [31:0]  status, rd_data;

  // Extra MSB on each pointer separates full (MSBs differ) from empty.
  assign tx_empty  = (tx_wp == tx_rp);
  assign tx_full   = (tx_wp[TAW] != tx_rp[TAW]) && (tx_wp[TAW-1:0] == tx_rp[TAW-1:0]);
  assign rx_empty  = (rx_wp == rx_rp);
  assign rx_full   = (rx_wp[RAW] != rx_rp[RAW]) && (rx_wp[RAW-1:0] == rx_rp[RAW-1:0]);
  assign rx_cnt    = rx_wp - rx_rp;
  assign tx_active = (tx_state != T_IDLE) || i_busy_tx;

  assign rd      = i_rd && !i_wr;
  assign wr_ctrl = i_wr && (i_addr == 2'd0);
  assign wr_stat = i_wr && (i_addr == 2'd1);
  assign wr_tx   = i_wr && (i_addr == 2'd2);
  assign rd_rx   = rd && (i_addr == 2'd3);
  assign flush   = wr_ctrl && ctrl[0] && !i_wdata[0];

  assign tx_pop  = ctrl[0] && !flush && (tx_state == T_IDLE) && !tx_empty && !i_busy_tx;
  assign tx_push = wr_tx && (!tx_full || tx_pop);
  assign rx_rise = i_rxne && !rxne_d;
  assign rx_pop  = rd_rx && !rx_empty;
  assign rx_push = rx_rise && !flush && (!rx_full || rx_pop);
  assign rx_drop = rx_rise && !flush && rx_full && !rx_pop;

  assign status = {16'h0, 8'(rx_cnt), 3'b0, tx_active, rx_ovr, tx_empty, !rx_empty, tx_full};

  always_comb begin
    rd_data = '0;
    case (i_addr)
      2'd0: rd_data = ctrl;
      2'd1: rd_data = status;
      2'd2: rd_data = '0;
      2'd3: if (!rx_empty) rd_data = {24'h0, rx_mem[rx_rp[RAW-1:0]]};
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (tx_push) tx_mem[tx_wp[TAW-1:0]] <= i_wdata[7:0];
    if (rx_push) rx_mem[rx_wp[RAW-1:0]] <= i_data_rx;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      ctrl      <= '0;
      tx_wp     <= '0;
      tx_rp     <= '0;
      rx_wp     <= '0;
      rx_rp     <= '0;
      rx_ovr    <= 1'b0;
      rxne_d    <= 1'b0;
      gap_cnt   <= 1'b0;
      tx_state  <= T_IDLE;
      o_str_tx  <= 1'b0;
      o_data_tx <= '0;
      o_rdata   <= '0;
      o_rvalid  <= 1'b0;
    end else begin
      rxne_d   <= i_rxne;
      o_rvalid <= rd;
      o_rdata  <= rd ? rd_data : '0;
      if (wr_ctrl) ctrl <= i_wdata & 32'h0000_FFFD;
      if (wr_stat && i_wdata[3]) rx_ovr <= 1'b0;
      if (rx_drop) rx_ovr <= 1'b1;
      if (flush) begin
        tx_wp    <= '0;
        tx_rp    <= '0;
        rx_wp    <= '0;
        rx_rp    <= '0;
        tx_state <= T_IDLE;
        o_str_tx <= 1'b0;
      end else begin
        if (tx_push) tx_wp <= tx_wp + 1'b1;
        if (tx_pop)  tx_rp <= tx_rp + 1'b1;
        if (rx_push) rx_wp <= rx_wp + 1'b1;
        if (rx_pop)  rx_rp <= rx_rp + 1'b1;
        case (tx_state)
          T_IDLE: if (tx_pop) begin
            o_data_tx <= tx_mem[tx_rp[TAW-1:0]];
            o_str_tx  <= 1'b1;
            tx_state  <= T_REQ;
          end
          T_REQ: if (i_busy_tx) begin
            o_str_tx <= 1'b0;
            tx_state <= T_ACTIVE;
          end
          T_ACTIVE: if (!i_busy_tx) begin
            gap_cnt  <= 1'b0;
            tx_state <= T_GAP;
          end
          // Two quiet cycles let the core fall back from done to idle.
          T_GAP: begin
            gap_cnt <= 1'b1;
            if (gap_cnt) tx_state <= T_IDLE;
          end
        endcase
      end
    end
  end

  assign o_en      = ctrl[0];
  assign o_br      = ctrl[7:4];
  assign o_clk_dec = ctrl[15:8];
  assign o_irq     = (!rx_empty && ctrl[2]) || (tx_empty && ctrl[3]);
endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// tb/tb_uart_mmio_ctrl.sv - randomized bench with queue-based reference model
// A small core stand-in drives i_busy_tx in response to o_str_tx.
module tb_uart_mmio_ctrl;
  localparam int TXD = 8;
  localparam int RXD = 8;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [1:0]  i_addr = '0;
  logic        i_wr = 1'b0;
  logic        i_rd = 1'b0;
  logic [31:0] i_wdata = '0;
  logic [31:0] o_rdata;
  logic        o_rvalid;
  logic        o_en;
  logic [3:0]  o_br;
  logic [7:0]  o_clk_dec;
  logic        o_str_tx;
  logic [7:0]  o_data_tx;
  logic        i_busy_tx = 1'b0;
  logic        i_rxne = 1'b0;
  logic [7:0]  i_data_rx = '0;
  logic        o_irq;

  uart_mmio_ctrl #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_addr(i_addr), .i_wr(i_wr), .i_rd(i_rd),
    .i_wdata(i_wdata), .o_rdata(o_rdata), .o_rvalid(o_rvalid), .o_en(o_en),
    .o_br(o_br), .o_clk_dec(o_clk_dec), .o_str_tx(o_str_tx), .o_data_tx(o_data_tx),
    .i_busy_tx(i_busy_tx), .i_rxne(i_rxne), .i_data_rx(i_data_rx), .o_irq(o_irq)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFOs as queues, transmitter as a timeline of start/busy/hold-off.
  logic [7:0]  txq[$];
  logic [7:0]  rxq[$];
  logic [31:0] m_ctrl = '0;
  logic [31:0] m_rdata = '0;
  logic [7:0]  m_data = '0;
  bit          m_ovr, m_str, m_infl, m_rxne_d, m_rvalid, model_ok;
  int          cyc = 0;
  int          hold_until = 0;

  function automatic logic [31:0] m_status();
    logic act;
    act = m_str || m_infl || (cyc < hold_until) || i_busy_tx;
    return {16'h0, 8'(rxq.size()), 3'b0, act, m_ovr, txq.size() == 0, rxq.size() != 0, txq.size() == TXD};
  endfunction

  always @(posedge i_clk) begin
    bit rd, flush, rise;
    if (!i_rst) begin
      txq.delete(); rxq.delete();
      m_ctrl = '0; m_ovr = 0; m_str = 0; m_infl = 0; m_data = '0;
      hold_until = 0; m_rxne_d = 0; m_rvalid = 0; m_rdata = '0;
    end else begin
      rd    = i_rd && !i_wr;
      flush = i_wr && i_addr == 2'd0 && m_ctrl[0] && !i_wdata[0];
      rise  = i_rxne && !m_rxne_d;
      m_rxne_d = i_rxne;
      m_rvalid = rd;
      m_rdata  = '0;
      if (rd) begin
        if (i_addr == 2'd0) m_rdata = m_ctrl;
        else if (i_addr == 2'd1) m_rdata = m_status();
        else if (i_addr == 2'd3 && rxq.size() > 0) m_rdata = {24'h0, rxq[0]};
      end
      if (i_wr && i_addr == 2'd1 && i_wdata[3]) m_ovr = 0;
      if (flush) begin
        txq.delete(); rxq.delete();
        m_str = 0; m_infl = 0; hold_until = 0;
      end else begin
        if (m_str) begin
          if (i_busy_tx) m_str = 0;
        end else if (m_infl) begin
          if (!i_busy_tx) begin m_infl = 0; hold_until = cyc + 3; end
        end else if (m_ctrl[0] && cyc >= hold_until && txq.size() > 0 && !i_busy_tx) begin
          m_data = txq.pop_front(); m_str = 1; m_infl = 1;
        end
        if (i_wr && i_addr == 2'd2 && txq.size() < TXD) txq.push_back(i_wdata[7:0]);
        if (rd && i_addr == 2'd3 && rxq.size() > 0) void'(rxq.pop_front());
        if (rise) begin
          if (rxq.size() < RXD) rxq.push_back(i_data_rx);
          else m_ovr = 1;
        end
      end
      if (i_wr && i_addr == 2'd0) m_ctrl = i_wdata & 32'h0000_FFFD;
    end
    cyc++;
  end

  always @(negedge i_clk) begin
    if (model_ok) begin
      chk("o_en", 32'(o_en), 32'(m_ctrl[0]));
      chk("o_br", 32'(o_br), 32'(m_ctrl[7:4]));
      chk("o_clk_dec", 32'(o_clk_dec), 32'(m_ctrl[15:8]));
      chk("o_str_tx", 32'(o_str_tx), 32'(m_str));
      chk("o_data_tx", 32'(o_data_tx), 32'(m_data));
      chk("o_irq", 32'(o_irq), 32'((rxq.size() != 0 && m_ctrl[2]) || (txq.size() == 0 && m_ctrl[3])));
      chk("o_rvalid", 32'(o_rvalid), 32'(m_rvalid));
      if (m_rvalid) chk("o_rdata", o_rdata, m_rdata);
    end
  end

  // UART core stand-in: answers o_str_tx with a busy pulse of random length.
  int         core_st = 0;
  int         core_lat, core_len;
  bit         core_hold = 0;
  logic [7:0] sent[$];

  always @(negedge i_clk) begin
    if (!i_rst) begin
      i_busy_tx = 1'b0; core_st = 0;
    end else if (core_st == 0) begin
      if (o_str_tx) begin core_lat = $urandom_range(0, 2); core_st = 1; end
    end else if (core_st == 1) begin
      if (!o_str_tx) core_st = 0;
      else if (core_lat == 0) begin
        i_busy_tx = 1'b1; sent.push_back(o_data_tx);
        core_len = $urandom_range(2, 6); core_st = 2;
      end else core_lat--;
    end else if (!core_hold) begin
      if (core_len == 0) begin i_busy_tx = 1'b0; core_st = 0; end
      else core_len--;
    end
  end

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge i_clk); i_addr = a; i_wdata = d; i_wr = 1'b1; i_rd = 1'b0;
    @(negedge i_clk); i_wr = 1'b0;
  endtask

  task automatic bus_rd(input string name, input logic [1:0] a, input logic [31:0] exp);
    @(negedge i_clk); i_addr = a; i_rd = 1'b1; i_wr = 1'b0;
    @(negedge i_clk); i_rd = 1'b0;
    chk(name, o_rdata, exp);
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    @(negedge i_clk); i_rxne = 1'b1; i_data_rx = d;
    @(negedge i_clk);
    @(negedge i_clk); i_rxne = 1'b0;
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (!i_busy_tx && n < 20) begin @(negedge i_clk); n++; end
    chk(name, 32'(i_busy_tx), 32'd1);
  endtask

  task automatic wait_quiet(input string name);
    int streak = 0;
    for (int n = 0; n < 400 && streak < 8; n++) begin
      @(negedge i_clk);
      if (!i_busy_tx && !o_str_tx && core_st == 0) streak++;
      else streak = 0;
    end
    chk(name, 32'(streak >= 8), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r, rx_left;
    repeat (3) @(negedge i_clk);
    model_ok = 1;
    chk("rst_str_tx", 32'(o_str_tx), 0);
    chk("rst_data_tx", 32'(o_data_tx), 0);
    chk("rst_rdata", o_rdata, 0);
    chk("rst_irq", 32'(o_irq), 0);
    i_rst = 1'b1;
    bus_rd("rst_status", 2'd1, 32'h4);
    bus_rd("rst_ctrl", 2'd0, 32'h0);

    bus_wr(2'd0, 32'h0000_1B41);
    chk("ctrl_en", 32'(o_en), 1);
    chk("ctrl_br", 32'(o_br), 4);
    chk("ctrl_clk", 32'(o_clk_dec), 32'h1B);
    bus_rd("ctrl_read", 2'd0, 32'h0000_1B41);
    sent.delete();
    bus_wr(2'd2, 32'h55);
    @(negedge i_clk);
    chk("single_str", 32'(o_str_tx), 1);
    chk("single_data", 32'(o_data_tx), 32'h55);
    wait_quiet("single_done");
    chk("single_sent", 32'(sent.size() == 1 ? sent[0] : 8'h00), 32'h55);

    bus_wr(2'd2, 32'h33);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("midrst_str", 32'(o_str_tx), 0);
    chk("midrst_en", 32'(o_en), 0);
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    bus_rd("midrst_status", 2'd1, 32'h4);
    bus_rd("midrst_ctrl", 2'd0, 32'h0);

    bus_wr(2'd0, 32'h0000_1B41);
    sent.delete();
    core_hold = 1;
    bus_wr(2'd2, 32'h01);
    wait_busy("burst_busy");
    for (int i = 2; i <= 9; i++) bus_wr(2'd2, 32'(i));
    bus_rd("burst_full", 2'd1, 32'h11);
    bus_wr(2'd2, 32'h77);
    core_hold = 0;
    wait_quiet("burst_done");
    chk("burst_count", 32'(sent.size()), 9);
    for (int i = 0; i < 9; i++) chk("burst_order", 32'(i < sent.size() ? sent[i] : 8'h00), 32'(i + 1));

    rx_pulse(8'hA5);
    bus_rd("rx_status", 2'd1, 32'h106);
    bus_rd("rx_data", 2'd3, 32'hA5);
    bus_rd("rx_empty", 2'd1, 32'h4);

    for (int i = 1; i <= 9; i++) rx_pulse(8'(i));
    bus_rd("ovr_status", 2'd1, 32'h80E);
    for (int i = 1; i <= 8; i++) bus_rd("ovr_data", 2'd3, 32'(i));
    bus_rd("ovr_sticky", 2'd1, 32'h0C);
    bus_wr(2'd1, 32'h8);
    bus_rd("ovr_clear", 2'd1, 32'h4);

    for (int i = 0; i < 8; i++) rx_pulse(8'(8'h10 + i));
    @(negedge i_clk); i_rxne = 1'b1; i_data_rx = 8'h18; i_addr = 2'd3; i_rd = 1'b1;
    @(negedge i_clk); i_rd = 1'b0;
    chk("fullpop_data", o_rdata, 32'h10);
    @(negedge i_clk); i_rxne = 1'b0;
    bus_rd("fullpop_status", 2'd1, 32'h806);
    for (int i = 1; i <= 8; i++) bus_rd("fullpop_drain", 2'd3, 32'(8'h10 + i));

    core_hold = 1;
    bus_wr(2'd2, 32'hA1);
    wait_busy("flush_busy");
    bus_wr(2'd2, 32'hA2); bus_wr(2'd2, 32'hA3); bus_wr(2'd2, 32'hA4);
    rx_pulse(8'hB1); rx_pulse(8'hB2);
    bus_wr(2'd0, 32'h0000_1B40);
    chk("flush_en", 32'(o_en), 0);
    chk("flush_str", 32'(o_str_tx), 0);
    core_hold = 0;
    wait_quiet("flush_quiet");
    bus_rd("flush_status", 2'd1, 32'h4);
    bus_rd("flush_rx", 2'd3, 32'h0);

    bus_wr(2'd0, 32'h8);
    chk("irq_tx", 32'(o_irq), 1);
    bus_wr(2'd0, 32'h5);
    chk("irq_none", 32'(o_irq), 0);
    rx_pulse(8'h5A);
    chk("irq_rx", 32'(o_irq), 1);
    bus_rd("irq_pop", 2'd3, 32'h5A);
    chk("irq_clear", 32'(o_irq), 0);

    bus_wr(2'd0, 32'h0000_1B0D);
    rx_left = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge i_clk);
      r = $urandom_range(0, 99);
      i_wr = 1'b0; i_rd = 1'b0;
      i_wdata = $urandom;
      i_addr = 2'($urandom_range(0, 3));
      if (r < 5) begin
        i_addr = 2'd0; i_wdata[0] = ($urandom_range(0, 9) != 0); i_wr = 1'b1;
      end else if (r < 9) begin
        i_addr = 2'd1; i_wr = 1'b1;
      end else if (r < 40) begin
        i_addr = 2'd2; i_wr = 1'b1;
      end else if (r < 65) begin
        if ($urandom_range(0, 1) == 1) i_addr = 2'd3;
        i_rd = 1'b1;
      end else if (r < 67) begin
        i_wr = 1'b1; i_rd = 1'b1;
      end
      if (rx_left > 0) begin
        rx_left--;
        if (rx_left == 0) i_rxne = 1'b0;
      end else if (!i_rxne && $urandom_range(0, 5) == 0) begin
        i_rxne = 1'b1; i_data_rx = 8'($urandom); rx_left = 2;
      end
    end
    @(negedge i_clk);
    i_wr = 1'b0; i_rd = 1'b0; i_rxne = 1'b0;
    wait_quiet("final_quiet");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_mmio_ctrl.md
Name: uart_mmio_ctrl

Overview:
CPU-side memory-mapped controller for the UART peripheral core. It drives the core's control inputs (en, baud code, clock code, str_tx, data_tx) and consumes its outputs (busy_tx, RXNE, data_rx). TX and RX FIFOs decouple the RV32I load/store bus from serial timing, so firmware never has to poll the single-cycle RXNE or hand-toggle STRTX. It sits between the CPU data bus decoder and the UART core.

Parameters:
TX_DEPTH, 8, TX FIFO entries; power of 2, minimum 2.
RX_DEPTH, 8, RX FIFO entries; power of 2, minimum 2.

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset, synchronous, active-low
i_addr  in  2  word select: 0 CTRL, 1 STATUS, 2 TXDATA, 3 RXDATA
i_wr  in  1  bus write strobe, 1 cycle
i_rd  in  1  bus read strobe, 1 cycle
i_wdata  in  32  write data
o_rdata  out  32  read data, registered
o_rvalid  out  1  o_rdata valid, 1 cycle
o_en  out  1  to core i_en (CTRL[0])
o_br  out  4  to core i_br (CTRL[7:4])
o_clk_dec  out  8  to core i_clk_dec (CTRL[15:8])
o_str_tx  out  1  to core i_str_tx
o_data_tx  out  8  to core i_data_tx
i_busy_tx  in  1  from core o_busy_tx
i_rxne  in  1  from core o_RXNE
i_data_rx  in  8  from core o_data_rx
o_irq  out  1  level: (RX not empty & CTRL[2]) | (TX empty & CTRL[3])

Behaviour:
- Reset (i_rst=0): CTRL=0, both FIFOs empty, RX_OVR=0, TX FSM=T_IDLE, o_str_tx=0, o_data_tx=0, o_rdata=0, o_rvalid=0, o_irq=0.
- CTRL (rw): bit0 EN, bit2 RXIE, bit3 TXIE, [7:4] BR, [15:8] CLK; other bits read 0. Write EN 1->0: flush both FIFOs, force TX FSM to T_IDLE, drop o_str_tx in the same cycle.
- STATUS (r): bit0 TX_FULL, bit1 RX_NE, bit2 TX_EMPTY, bit3 RX_OVR (sticky), bit4 TX_ACTIVE (FSM not T_IDLE or i_busy_tx), [15:8] RX count. Writing STATUS with wdata[3]=1 clears RX_OVR; all other bits ignored.
- TXDATA (w): push wdata[7:0] if not full; if full, drop the byte silently. Reads return 0.
- RXDATA (r): return the head byte in [7:0] and pop. If empty, return 0 and do not pop. Writes are ignored.
- Read latency: o_rdata/o_rvalid are registered, valid in the cycle after i_rd. i_rd and i_wr are never asserted together; if they are, the write wins and o_rvalid=0.
- TX FSM (runs only when EN=1):
  - T_IDLE: if FIFO not empty and !i_busy_tx, pop head into o_data_tx, set o_str_tx=1, go T_REQ.
  - T_REQ: hold o_str_tx=1 until i_busy_tx=1, then o_str_tx=0 and go T_ACTIVE.
  - T_ACTIVE: hold o_data_tx stable (the core latches it at the end of the start bit); when i_busy_tx=0, go T_GAP.
  - T_GAP: 2 cycles with o_str_tx=0, so the core leaves its done state and reaches idle; then go T_IDLE.
  - Back-to-back bytes: minimum gap between stop bit end and the next o_str_tx rise is 3 cycles.
- RX capture: i_rxne is high for 2 consecutive cycles per byte. Push only on the rising edge (i_rxne & !rxne_d), using i_data_rx. If the FIFO is full, drop the byte and set RX_OVR.
- Simultaneous RX push and RXDATA pop: both take effect, count unchanged. At full, a same-cycle pop frees the slot, so the push succeeds and RX_OVR is not set.
- Simultaneous TX push and FSM pop: both take effect. At full, the pop frees the slot, so the push is accepted.
- FIFO pointers wrap modulo depth; an extra pointer bit distinguishes full from empty.

Test Plan:
- Reset: drive i_rst=0 mid-transmission -> next cycle o_str_tx=0, STATUS=0x04, CTRL reads 0.
- TX single byte: write CTRL=0x00001B41 (EN, BR=4), write TXDATA=0x55 -> o_str_tx rises 1 cycle later with o_data_tx=0x55; o_str_tx falls the cycle after i_busy_tx=1; o_data_tx holds 0x55 until i_busy_tx=0.
- TX burst: write 9 bytes 0x01..0x09 with TX_DEPTH=8 while the bench model holds i_busy_tx=1 -> first popped into FSM, 8 queued, none dropped; then 0x01..0x09 emitted in order with at least 3 cycles of o_str_tx=0 between frames.
- RX edge capture: pulse i_rxne for 2 cycles with i_data_rx=0xA5 -> exactly one entry, STATUS[15:8]=1; read RXDATA -> o_rdata=0x000000A5 with o_rvalid one cycle later, then STATUS[1]=0.
- RX overflow: push 9 bytes with no reads -> STATUS[3]=1, count=8, reads return bytes 1..8; write STATUS=0x8 -> RX_OVR=0.
- Disable flush: queue 3 TX and 2 RX bytes, write CTRL EN=0 -> o_en=0 and o_str_tx=0 that cycle, STATUS reads 0x04 (TX_EMPTY only, count 0).
